// File: rtl/bp_axil_mmio_req_buffer_pkg.sv
// rtl/bp_axil_mmio_req_buffer_pkg.sv - register map, response codes and push states shared with the polling host
package bp_axil_mmio_req_buffer_pkg;

   localparam logic [7:0] mmio_els_offset_gp = 8'h00;
   localparam logic [7:0] mmio_cnt_offset_gp = 8'h08;
   localparam logic [7:0] mmio_pop_offset_gp = 8'h0C;

   localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
   localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

   typedef enum logic [1:0] {
      e_ready,
      e_push_addr,
      e_push_data
   } push_state_e;

endpackage

// File: rtl/bp_axil_mmio_req_buffer_fifo.sv
// rtl/bp_axil_mmio_req_buffer_fifo.sv - single-clock word FIFO storage; occupancy is tracked by the caller
module bp_axil_mmio_req_buffer_fifo #(
   parameter int els_p   = 64,
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   input  logic               yumi_i,
   output logic [width_p-1:0] data_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] wptr_q, wptr_d;
   logic [ptr_w_lp-1:0] rptr_q, rptr_d;

   // els_p need not be a power of two, so pointers wrap explicitly
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (v_i) begin
         wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (yumi_i) begin
         rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (v_i && !reset_i) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/bp_axil_mmio_req_buffer.sv
// rtl/bp_axil_mmio_req_buffer.sv - buffers BP MMIO commands as addr/data word pairs, drained by an AXI-Lite read port
module bp_axil_mmio_req_buffer
   import bp_axil_mmio_req_buffer_pkg::*;
#(
   parameter int els_p             = 64,
   parameter int S_AXIL_ADDR_WIDTH = 64,
   parameter int S_AXIL_DATA_WIDTH = 32
) (
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic                         cmd_v_i,
   input  logic [31:0]                  cmd_addr_i,
   input  logic [31:0]                  cmd_data_i,
   output logic                         cmd_ready_and_o,

   input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr_i,
   input  logic                         s_axil_arvalid_i,
   output logic                         s_axil_arready_o,
   input  logic [2:0]                   s_axil_arprot_i,

   output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata_o,
   output logic [1:0]                   s_axil_rresp_o,
   output logic                         s_axil_rvalid_o,
   input  logic                         s_axil_rready_i
);

   localparam int cnt_w_lp = $clog2(els_p + 1);

   push_state_e         state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         data_q, data_d;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                cmd_ready;
   logic                has_room;
   logic                push_v;
   logic [31:0]         push_word;
   logic                pop_v;
   logic [31:0]         head_word;
   logic                ar_hs;
   logic [7:0]          offset;
   logic                rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic                unused_ok;

   assign unused_ok = ^{s_axil_arprot_i, s_axil_araddr_i[S_AXIL_ADDR_WIDTH-1:8]};

   // A whole pair must fit before accepting, so a pair is never split
   assign has_room = (cnt_w_lp'(els_p) - cnt_q) >= cnt_w_lp'(2);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cmd_ready = 1'b0;
      push_v    = 1'b0;
      push_word = '0;
      unique case (state_q)
         e_ready: begin
            cmd_ready = has_room;
            if (cmd_v_i && has_room) begin
               addr_d  = cmd_addr_i;
               data_d  = cmd_data_i;
               state_d = e_push_addr;
            end
         end
         e_push_addr: begin
            push_v    = 1'b1;
            push_word = addr_q;
            state_d   = e_push_data;
         end
         e_push_data: begin
            push_v    = 1'b1;
            push_word = data_q;
            state_d   = e_ready;
         end
         default: state_d = e_ready;
      endcase
   end

   assign ar_hs  = s_axil_arvalid_i & s_axil_arready_o;
   assign offset = s_axil_araddr_i[7:0];

   always_comb begin
      pop_v    = 1'b0;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         case (offset)
            mmio_els_offset_gp: begin
               rdata_d = 32'(els_p);
               rresp_d = axil_resp_okay_gp;
            end
            mmio_cnt_offset_gp: begin
               rdata_d = 32'(cnt_q);
               rresp_d = axil_resp_okay_gp;
            end
            mmio_pop_offset_gp: begin
               if (cnt_q != '0) begin
                  pop_v   = 1'b1;
                  rdata_d = head_word;
                  rresp_d = axil_resp_okay_gp;
               end else begin
                  rdata_d = '0;
                  rresp_d = axil_resp_slverr_gp;
               end
            end
            default: begin
               rdata_d = '0;
               rresp_d = axil_resp_slverr_gp;
            end
         endcase
      end else if (rvalid_q && s_axil_rready_i) begin
         rvalid_d = 1'b0;
      end
   end

   assign cnt_d = cnt_q + cnt_w_lp'(push_v) - cnt_w_lp'(pop_v);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= e_ready;
         addr_q   <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   bp_axil_mmio_req_buffer_fifo #(
      .els_p   (els_p),
      .width_p (32)
   ) fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (push_v),
      .data_i  (push_word),
      .yumi_i  (pop_v),
      .data_o  (head_word)
   );

   assign cmd_ready_and_o  = cmd_ready & ~reset_i;
   assign s_axil_arready_o = ~rvalid_q & ~reset_i;
   assign s_axil_rvalid_o  = rvalid_q;
   assign s_axil_rdata_o   = rdata_q;
   assign s_axil_rresp_o   = rresp_q;

endmodule

// File: tb/tb_bp_axil_mmio_req_buffer.sv
// tb/tb_bp_axil_mmio_req_buffer.sv - queue-model scoreboard plus directed register-read scenarios
module tb_bp_axil_mmio_req_buffer;

   localparam int ELS = 64;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_v;
   logic [31:0] cmd_addr, cmd_data;
   logic        cmd_ready;
   logic [63:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bp_axil_mmio_req_buffer #(
      .els_p             (ELS),
      .S_AXIL_ADDR_WIDTH (64),
      .S_AXIL_DATA_WIDTH (32)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .cmd_v_i          (cmd_v),
      .cmd_addr_i       (cmd_addr),
      .cmd_data_i       (cmd_data),
      .cmd_ready_and_o  (cmd_ready),
      .s_axil_araddr_i  (araddr),
      .s_axil_arvalid_i (arvalid),
      .s_axil_arready_o (arready),
      .s_axil_arprot_i  (3'b101),
      .s_axil_rdata_o   (rdata),
      .s_axil_rresp_o   (rresp),
      .s_axil_rvalid_o  (rvalid),
      .s_axil_rready_i  (rready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: buffered words, words still waiting to be pushed, and one pending read response
   logic [31:0] m_q[$];
   logic [31:0] m_pend[$];
   bit          m_rv = 1'b0;
   logic [31:0] m_rd = '0;
   logic [1:0]  m_rr = '0;
   bit          chk_en = 1'b0;
   bit          cmd_hs, ar_hs, r_hs;
   logic [7:0]  off;

   function automatic bit m_ready();
      return !reset && (m_pend.size() == 0) && ((ELS - m_q.size()) >= 2);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_pend.delete();
         m_rv = 1'b0;
         m_rd = '0;
         m_rr = '0;
      end else begin
         cmd_hs = cmd_v && m_ready();
         ar_hs  = arvalid && !m_rv;
         r_hs   = m_rv && rready;
         off    = araddr[7:0];
         if (ar_hs) begin
            m_rv = 1'b1;
            if (off == 8'h00) begin
               m_rd = ELS; m_rr = OKAY;
            end else if (off == 8'h08) begin
               m_rd = 32'(m_q.size()); m_rr = OKAY;
            end else if (off == 8'h0C && m_q.size() > 0) begin
               m_rd = m_q.pop_front(); m_rr = OKAY;
            end else begin
               m_rd = 0; m_rr = SLVERR;
            end
         end else if (r_hs) begin
            m_rv = 1'b0;
         end
         if (m_pend.size() > 0) m_q.push_back(m_pend.pop_front());
         if (cmd_hs) begin
            m_pend.push_back(cmd_addr);
            m_pend.push_back(cmd_data);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_ready()});
         chk("arready", {31'b0, arready}, {31'b0, !reset && !m_rv});
         chk("rvalid", {31'b0, rvalid}, {31'b0, m_rv});
         if (m_rv) begin
            chk("rdata", rdata, m_rd);
            chk("rresp", {30'b0, rresp}, {30'b0, m_rr});
         end
      end
   end

   task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      int t;
      @(posedge clk); #1;
      araddr  = 64'hABCD_0000_0000_0000 | 64'(a);
      arvalid = 1'b1;
      rready  = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!arready && t < 20);
      if (!arready) chk("ar_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         t++;
         if (rvalid) break;
      end
      if (!rvalid) chk("r_timeout", 32'd0, 32'd1);
      d = rdata;
      r = rresp;
      @(posedge clk); #1;
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er, input string name);
      logic [31:0] d;
      logic [1:0]  r;
      rd(a, d, r);
      chk({name, "_data"}, d, ed);
      chk({name, "_resp"}, {30'b0, r}, {30'b0, er});
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      int t;
      @(posedge clk); #1;
      cmd_v = 1'b1; cmd_addr = a; cmd_data = d;
      t = 0;
      do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
      if (!cmd_ready) chk("cmd_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_v = 1'b0; cmd_addr = '0; cmd_data = '0;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_arready", {31'b0, arready}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      rd_chk(8'h08, 32'd0, OKAY, "empty_cnt");
      rd_chk(8'h0C, 32'd0, SLVERR, "empty_pop");
      rd_chk(8'h08, 32'd0, OKAY, "empty_cnt2");
      rd_chk(8'h00, 32'd64, OKAY, "els");

      send(32'h0010_1000, 32'h41);
      rd_chk(8'h08, 32'd2, OKAY, "one_cnt");
      rd_chk(8'h0C, 32'h0010_1000, OKAY, "one_addr");
      rd_chk(8'h0C, 32'h41, OKAY, "one_data");
      rd_chk(8'h08, 32'd0, OKAY, "one_cnt0");

      for (int i = 0; i < ELS / 2; i++) send(32'h1000 + i, 32'hD000 + i);
      @(negedge clk);
      chk("full_ready", {31'b0, cmd_ready}, 32'd0);
      rd_chk(8'h08, 32'd64, OKAY, "full_cnt");
      rd_chk(8'h0C, 32'h1000, OKAY, "full_pop0");
      @(negedge clk);
      chk("cnt63_ready", {31'b0, cmd_ready}, 32'd0);
      rd_chk(8'h08, 32'd63, OKAY, "cnt63");
      rd_chk(8'h0C, 32'hD000, OKAY, "full_pop1");
      @(negedge clk);
      chk("cnt62_ready", {31'b0, cmd_ready}, 32'd1);
      for (int k = 2; k < ELS; k++)
         rd_chk(8'h0C, (k % 2 == 1) ? 32'hD000 + k / 2 : 32'h1000 + k / 2, OKAY, "drain");
      rd_chk(8'h08, 32'd0, OKAY, "drained_cnt");

      send(32'hA1, 32'hD1);
      @(posedge clk); #1;
      cmd_v = 1'b1; cmd_addr = 32'hA2; cmd_data = 32'hD2;
      @(negedge clk);
      chk("ovl_ready", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_v = 1'b0;
      @(posedge clk); #1;
      araddr = 64'h0C; arvalid = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("ovl_rvalid", {31'b0, rvalid}, 32'd1);
      chk("ovl_pop", rdata, 32'hA1);
      @(posedge clk); #1;
      rd_chk(8'h08, 32'd3, OKAY, "ovl_cnt");
      rd_chk(8'h0C, 32'hD1, OKAY, "ovl_d1");
      rd_chk(8'h0C, 32'hA2, OKAY, "ovl_a2");
      rd_chk(8'h0C, 32'hD2, OKAY, "ovl_d2");
      rd_chk(8'h08, 32'd0, OKAY, "ovl_cnt0");

      @(posedge clk); #1;
      rready = 1'b0; arvalid = 1'b1; araddr = 64'h0;
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_rvalid", {31'b0, rvalid}, 32'd1);
         chk("hold_arready", {31'b0, arready}, 32'd0);
         chk("hold_rdata", rdata, 32'd64);
         chk("hold_rresp", {30'b0, rresp}, 32'd0);
      end
      @(posedge clk); #1;
      rready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_done", {31'b0, rvalid}, 32'd0);
      rd_chk(8'h04, 32'd0, SLVERR, "bad_off4");
      rd_chk(8'h10, 32'd0, SLVERR, "bad_off10");

      @(posedge clk); #1;
      cmd_v = 1'b1; cmd_addr = 32'h55; cmd_data = 32'h66;
      rready = 1'b0; arvalid = 1'b1; araddr = 64'h0;
      @(posedge clk); #1;
      cmd_v = 1'b0; arvalid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0; rready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stray_r", {31'b0, rvalid}, 32'd0);
      end
      rd_chk(8'h08, 32'd0, OKAY, "post_rst_cnt");
      rd_chk(8'h0C, 32'd0, SLVERR, "post_rst_pop");

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
